// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM states and widths for the multiply/divide engine.
package muldiv_pkg;

  localparam int unsigned MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX
  } muldiv_state_t;

  // MULT and DIV (even codes of the arithmetic group) are the signed variants
  function automatic logic op_is_signed(input logic [MD_OP_W-1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_abs_negate.sv
// Conditional two's-complement: result = en ? -value : value.
module abs_negate #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] result
);

  assign result = en ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; MTHI/MTLO write directly.
// Define FAST_MULT_EN for single-cycle combinational MULT/MULTU.
module mult_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int unsigned     CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] iter_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
  logic             is_div_q, neg_q_q, neg_a_q, div_zero_q;

  logic             accept, op_iter, op_sgn;
  logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]   add_sum, shifted, diff;

  assign accept = start && (state_q == MD_IDLE);
  assign op_sgn = op_is_signed(op);

`ifdef FAST_MULT_EN
  assign op_iter = (op == MD_DIV) || (op == MD_DIVU);

  logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;
  // Low 2*WIDTH bits of a sign-extended product equal the signed product
  always_comb begin
    a_ext     = {{WIDTH{op_sgn & a[WIDTH-1]}}, a};
    b_ext     = {{WIDTH{op_sgn & b[WIDTH-1]}}, b};
    fast_prod = a_ext * b_ext;
  end
`else
  assign op_iter = ~op[MD_OP_W-1];
`endif

  abs_negate #(.WIDTH(WIDTH)) u_mag_a (
    .value(a), .en(op_sgn & a[WIDTH-1]), .result(a_mag)
  );
  abs_negate #(.WIDTH(WIDTH)) u_mag_b (
    .value(b), .en(op_sgn & b[WIDTH-1]), .result(b_mag)
  );
  abs_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
    .value({acc_hi_q, acc_lo_q}), .en(neg_q_q), .result(prod_fix)
  );
  abs_negate #(.WIDTH(WIDTH)) u_fix_quo (
    .value(acc_lo_q), .en(neg_q_q), .result(quo_fix)
  );
  abs_negate #(.WIDTH(WIDTH)) u_fix_rem (
    .value(acc_hi_q), .en(neg_a_q), .result(rem_fix)
  );

  // acc_lo holds the multiplier (shifted out LSB-first) or the dividend/quotient
  always_comb begin
    add_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {acc_hi_q, acc_lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, opnd_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MD_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = (state_q != MD_IDLE);
    case (state_q)
      MD_IDLE: if (accept && op_iter) state_d = MD_RUN;
      MD_RUN:  if (iter_q == LAST)    state_d = MD_FIX;
      MD_FIX:  state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (op_iter) begin
              acc_hi_q   <= '0;
              acc_lo_q   <= a_mag;
              opnd_q     <= b_mag;
              iter_q     <= '0;
              is_div_q   <= op[1];
              neg_q_q    <= op_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_a_q    <= op_sgn & a[WIDTH-1];
              div_zero_q <= (b == '0);
`ifdef FAST_MULT_EN
            end else if ((op == MD_MULT) || (op == MD_MULTU)) begin
              {hi, lo} <= fast_prod;
              done     <= 1'b1;
`endif
            end else if (op == MD_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == MD_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end
          end
        end
        MD_RUN: begin
          iter_q <= iter_q + CNT_W'(1);
          if (!is_div_q) begin
            acc_hi_q <= add_sum[WIDTH:1];
            acc_lo_q <= {add_sum[0], acc_lo_q[WIDTH-1:1]};
          end else if (!diff[WIDTH]) begin
            acc_hi_q <= diff[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_q <= shifted[WIDTH-1:0];
            acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
          end
        end
        MD_FIX: begin
          // With a zero divisor the remainder path ends holding |a|; sign-fixing restores raw a
          if (is_div_q) begin
            lo <= div_zero_q ? '1 : quo_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit (default build, iterative multiply).
module tb_mult_div_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
  localparam int LAT_ITER = W + 2;  // edges from the start edge through the done edge, inclusive
  localparam int LAT_MT   = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    string        tag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    longint sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      3'd0: return sx * sy;
      3'd1: return ux * uy;
      3'd2: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == '0) return {x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Call on a falling edge; returns on the falling edge after the start edge.
  task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] ehi,
                       input logic [W-1:0] elo, input int lat);
    exp_t e;
    e.tag = tag; e.hi = ehi; e.lo = elo; e.lat = lat; e.start_cyc = cyc + 1;
    sb.push_back(e);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_hi"}, hi, mon_e.hi);
        check({mon_e.tag, "_lo"}, lo, mon_e.lo);
        check({mon_e.tag, "_lat"}, cyc - mon_e.start_cyc + 1, mon_e.lat);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry;
    logic [63:0]  m;
    int           n;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, LAT_ITER);
    check("mult_busy", busy, 1);
    check("mult_lo_hold", lo, 0);
    drain(60);
    issue("multu_ff", MD_MULTU, '1, '1, 32'hFFFF_FFFE, 32'h1, LAT_ITER);
    drain(60);
    issue("mult_ff", MD_MULT, '1, '1, 32'h0, 32'h1, LAT_ITER);
    drain(60);

    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_ITER);
    drain(60);
    issue("divu_7_2", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, LAT_ITER);
    drain(60);
    issue("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, LAT_ITER);
    drain(60);

    issue("div_by0", MD_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, LAT_ITER);
    drain(60);
    issue("div_neg_by0", MD_DIV, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, LAT_ITER);
    drain(60);
    issue("divu_by0", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, LAT_ITER);
    drain(60);
    issue("div_ovf", MD_DIV, 32'h8000_0000, '1, 32'h0, 32'h8000_0000, LAT_ITER);
    drain(60);
    issue("mult_zero", MD_MULT, 32'd0, 32'h0123_4567, 32'h0, 32'h0, LAT_ITER);
    drain(60);
    issue("divu_zero", MD_DIVU, 32'd0, 32'd9, 32'h0, 32'h0, LAT_ITER);
    drain(60);

    op = 3'b110; a = 32'h77; b = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rsv_busy", busy, 0);
    repeat (3) @(negedge clk);

    issue("mult_6x7", MD_MULT, 32'd6, 32'd7, 32'h0, 32'd42, LAT_ITER);
    repeat (3) @(negedge clk);
    op = MD_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    op = MD_MTHI; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    check("mthi_busy_ignored", hi, 0);
    check("busy_hold", busy, 1);
    drain(60);
    issue("mtlo", MD_MTLO, 32'hABCD, 32'd0, 32'h0, 32'hABCD, LAT_MT);
    check("mtlo_busy", busy, 0);
    drain(5);
    issue("mthi", MD_MTHI, 32'h55AA, 32'd0, 32'h55AA, 32'hABCD, LAT_MT);
    drain(5);

    // back-to-back: each new op starts on the cycle its predecessor's done is high
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 3) ? '0 : ((i % 2 == 1) ? ($urandom >> 20) : $urandom);
      m  = model(ro, rx, ry);
      if (i > 0) begin
        n = 0;
        while (!done && n < 60) begin
          @(negedge clk);
          n++;
        end
        if (!done) check("b2b_done_timeout", done, 1);
      end
      issue($sformatf("rand%0d", i), ro, rx, ry, m[63:32], m[31:0], LAT_ITER);
    end
    drain(80);

    issue("mid_rst", MD_MULTU, 32'h1234, 32'h5678, 32'h0, 32'h0, LAT_ITER);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, LAT_ITER);
    drain(60);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
